// File: rtl/ps2_main.sv
// PS/2 keyboard front end: serial receiver (or injected bytes when PS2_KEY_INJECT_EN
// is defined) feeding a scan-code decoder that assembles a BCD user ID.
module ps2_main #(
  parameter int unsigned ID_DIGITS   = 7,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   PS2_CLK,
  inout  logic                   PS2_DAT,
  input  logic [7:0]             key1_code,
  input  logic                   key1_on,
  output logic                   key_pressed,
  output logic                   buffer_full,
  output logic [4*ID_DIGITS-1:0] ID,
  output logic [3:0]             key,
  output logic                   esc_pressed,
  output logic                   ctrla_pressed
);

  localparam int unsigned CW = $clog2(ID_DIGITS + 1);

  logic       rx_valid;
  logic [7:0] rx_byte;

`ifdef PS2_KEY_INJECT_EN
  logic [2:0] inj_s;
  logic       unused_ps2;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) inj_s <= '0;
    else        inj_s <= {inj_s[1:0], key1_on};
  end

  assign rx_valid   = inj_s[1] & ~inj_s[2];
  assign rx_byte    = key1_code;
  assign unused_ps2 = PS2_CLK ^ PS2_DAT;
`else
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  rx_state_t     state;
  logic [1:0]    clk_s, dat_s;
  logic          clk_f, fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] tmo;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par;
  logic          unused_inject;

  assign unused_inject = ^{key1_code, key1_on};

  // Filtered clock only follows the input after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_s    <= '1;
      dat_s    <= '1;
      clk_f    <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DAT};
      fall  <= 1'b0;
      if (clk_s[1] != clk_f) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_f    <= clk_s[1];
          filt_cnt <= '0;
          fall     <= ~clk_s[1];
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= RX_IDLE;
      bit_idx  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tmo      <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (fall) begin
        tmo <= '0;
        case (state)
          RX_IDLE: begin
            bit_idx <= '0;
            if (!dat_s[1]) state <= RX_DATA;
          end
          RX_DATA: begin
            shreg   <= {dat_s[1], shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= dat_s[1];
            state <= RX_STOP;
          end
          default: begin
            state <= RX_IDLE;
            if (dat_s[1] && (^{shreg, par})) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end
          end
        endcase
      end else if (state != RX_IDLE) begin
        if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          state <= RX_IDLE;
          tmo   <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end
`endif

  function automatic logic [4:0] digit_of(input logic [7:0] code);
    case (code)
      8'h45, 8'h70: digit_of = {1'b1, 4'd0};
      8'h16, 8'h69: digit_of = {1'b1, 4'd1};
      8'h1E, 8'h72: digit_of = {1'b1, 4'd2};
      8'h26, 8'h7A: digit_of = {1'b1, 4'd3};
      8'h25, 8'h6B: digit_of = {1'b1, 4'd4};
      8'h2E, 8'h73: digit_of = {1'b1, 4'd5};
      8'h36, 8'h74: digit_of = {1'b1, 4'd6};
      8'h3D, 8'h6C: digit_of = {1'b1, 4'd7};
      8'h3E, 8'h75: digit_of = {1'b1, 4'd8};
      8'h46, 8'h7D: digit_of = {1'b1, 4'd9};
      default:      digit_of = '0;
    endcase
  endfunction

  logic [4:0]    dig;
  logic          ext, brk, ctrl_held;
  logic [7:0]    last_make;
  logic [CW-1:0] count;

  assign dig = digit_of(rx_byte);

  // A repeated make with no break in between is typematic and is dropped.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ID            <= '0;
      key           <= '0;
      count         <= '0;
      buffer_full   <= 1'b0;
      key_pressed   <= 1'b0;
      esc_pressed   <= 1'b0;
      ctrla_pressed <= 1'b0;
      ext           <= 1'b0;
      brk           <= 1'b0;
      ctrl_held     <= 1'b0;
      last_make     <= '0;
    end else begin
      key_pressed   <= 1'b0;
      esc_pressed   <= 1'b0;
      ctrla_pressed <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            last_make <= '0;
            if (rx_byte == 8'h14) ctrl_held <= 1'b0;
          end else if (rx_byte != last_make) begin
            last_make <= rx_byte;
            if (rx_byte == 8'h14) begin
              ctrl_held <= 1'b1;
            end else if (dig[4] && !ext) begin
              if (count != CW'(ID_DIGITS)) begin
                ID          <= {ID[4*ID_DIGITS-5:0], dig[3:0]};
                key         <= dig[3:0];
                count       <= count + 1'b1;
                buffer_full <= (count == CW'(ID_DIGITS - 1));
                key_pressed <= 1'b1;
              end
            end else if (rx_byte == 8'h76) begin
              key_pressed <= 1'b1;
              esc_pressed <= 1'b1;
            end else if (rx_byte == 8'h1C && ctrl_held) begin
              key_pressed   <= 1'b1;
              ctrla_pressed <= 1'b1;
            end else if (rx_byte == 8'h66 && count != '0) begin
              ID          <= ID >> 4;
              count       <= count - 1'b1;
              buffer_full <= 1'b0;
              key_pressed <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_main.sv
// Directed bench for ps2_main driving serial PS/2 frames through the default build.
`timescale 1ns/1ps
module tb_ps2_main;

  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        dat_drv = 1'b1;
  wire         ps2_dat;
  logic [7:0]  key1_code = '0;
  logic        key1_on = 1'b0;
  logic        key_pressed, buffer_full, esc_pressed, ctrla_pressed;
  logic [27:0] id;
  logic [3:0]  key;

  assign ps2_dat = dat_drv;

  ps2_main #(.ID_DIGITS(7), .FILTER_LEN(8), .TIMEOUT_CYC(1000)) dut (
    .CLK(clk), .reset(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .key1_code(key1_code), .key1_on(key1_on),
    .key_pressed(key_pressed), .buffer_full(buffer_full), .ID(id), .key(key),
    .esc_pressed(esc_pressed), .ctrla_pressed(ctrla_pressed)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int kp_cyc = 0, kp_rise = 0, esc_cyc = 0, ca_cyc = 0, lone = 0;
  logic kp_prev = 1'b0;

  always @(negedge clk) begin
    if (key_pressed) kp_cyc++;
    if (key_pressed && !kp_prev) kp_rise++;
    if (esc_pressed) esc_cyc++;
    if (ctrla_pressed) ca_cyc++;
    if ((esc_pressed || ctrla_pressed) && !key_pressed) lone++;
    kp_prev = key_pressed;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    dat_drv = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    dat_drv = 1'b1;
    wait_clk(30);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int kp0, esc0, ca0;

  initial begin
    wait_clk(5);
    check("reset_kp", {31'd0, key_pressed}, 32'd0);
    check("reset_id", {4'd0, id}, 32'd0);
    check("reset_bf", {31'd0, buffer_full}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    kp0 = kp_rise;
    send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0);
    send(8'h2E, 0); send(8'h36, 0); send(8'h3D, 0);
    check("fill_pulses", kp_rise - kp0, 32'd7);
    check("fill_id", {4'd0, id}, 32'h1234567);
    check("fill_bf", {31'd0, buffer_full}, 32'd1);
    check("fill_key", {28'd0, key}, 32'd7);

    kp0 = kp_rise;
    send(8'h46, 0);
    check("full_nopulse", kp_rise - kp0, 32'd0);
    check("full_id", {4'd0, id}, 32'h1234567);

    kp0 = kp_rise; esc0 = esc_cyc;
    send(8'h76, 0);
    check("esc_kp", kp_rise - kp0, 32'd1);
    check("esc_width", esc_cyc - esc0, 32'd1);
    check("esc_id", {4'd0, id}, 32'h1234567);

    kp0 = kp_rise; ca0 = ca_cyc;
    send(8'h14, 0); send(8'h1C, 0);
    check("ctrla_pulse", ca_cyc - ca0, 32'd1);
    check("ctrla_kp", kp_rise - kp0, 32'd1);

    ca0 = ca_cyc;
    send(8'hF0, 0); send(8'h14, 0); send(8'h1C, 0);
    check("ctrl_released", ca_cyc - ca0, 32'd0);

    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    kp0 = kp_rise;
    send(8'h16, 0); send(8'h16, 0); send(8'hF0, 0); send(8'h16, 0); send(8'h16, 0);
    check("typematic_id", {4'd0, id}, 32'h11);
    check("typematic_kp", kp_rise - kp0, 32'd2);
    check("typematic_key", {28'd0, key}, 32'd1);

    kp0 = kp_rise;
    send(8'h66, 0);
    check("bksp_id", {4'd0, id}, 32'h1);
    check("bksp_kp", kp_rise - kp0, 32'd1);
    check("bksp_bf", {31'd0, buffer_full}, 32'd0);

    kp0 = kp_rise;
    send(8'h26, 1);
    check("badpar_kp", kp_rise - kp0, 32'd0);
    check("badpar_id", {4'd0, id}, 32'h1);

    // Four bits of a frame then silence: the receiver must give up before the next frame.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    dat_drv = 1'b1;
    wait_clk(1500);
    send(8'h26, 0);
    check("timeout_id", {4'd0, id}, 32'h13);

    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_id", {4'd0, id}, 32'd0);
    check("midrst_key", {28'd0, key}, 32'd0);
    check("midrst_kp", {31'd0, key_pressed}, 32'd0);
    dat_drv = 1'b1;
    rst_n = 1'b1;
    wait_clk(50);
    send(8'h1E, 0);
    check("postrst_id", {4'd0, id}, 32'h2);
    check("postrst_key", {28'd0, key}, 32'd2);

    send(8'h66, 0);
    check("bksp_to_empty", {4'd0, id}, 32'd0);
    kp0 = kp_rise;
    send(8'hF0, 0); send(8'h66, 0); send(8'h66, 0);
    check("bksp_empty_kp", kp_rise - kp0, 32'd0);

    check("pulse_width", kp_cyc, kp_rise);
    check("flag_coincident", lone, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
